// File: rtl/alu_share_arbiter_if.sv
// Requester-side request/response bundle for alu_share_arbiter (two ports).
// No logic; the slave modport is the arbiter's view, master is the requesters'.
interface alu_share_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 4
);
    logic              req0_valid;
    logic              req0_ready;
    logic [OP_W-1:0]   req0_op;
    logic [DATA_W-1:0] req0_in1;
    logic [DATA_W-1:0] req0_in2;
    logic              req1_valid;
    logic              req1_ready;
    logic [OP_W-1:0]   req1_op;
    logic [DATA_W-1:0] req1_in1;
    logic [DATA_W-1:0] req1_in2;

    logic              rsp0_valid;
    logic              rsp0_ready;
    logic [DATA_W-1:0] rsp0_result;
    logic              rsp0_bcond;
    logic              rsp1_valid;
    logic              rsp1_ready;
    logic [DATA_W-1:0] rsp1_result;
    logic              rsp1_bcond;

    modport slave (
        input  req0_valid, req0_op, req0_in1, req0_in2,
        input  req1_valid, req1_op, req1_in1, req1_in2,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp0_result, rsp0_bcond,
        output rsp1_valid, rsp1_result, rsp1_bcond,
        input  rsp0_ready, rsp1_ready
    );

    modport master (
        output req0_valid, req0_op, req0_in1, req0_in2,
        output req1_valid, req1_op, req1_in1, req1_in2,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp0_result, rsp0_bcond,
        input  rsp1_valid, rsp1_result, rsp1_bcond,
        output rsp0_ready, rsp1_ready
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Purpose: shares one single-cycle ALU between EX stage (port 0) and branch/address helper (port 1).
// Latency: accept at T, response valid at T+2; min issue interval 3 cycles.
// Backpressure: holds in RESP until the owner's rsp_ready; no new accept meanwhile. ALU_ARB_FIXED_PRIO_EN = port 0 always wins.
module alu_share_arbiter #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    alu_share_arbiter_if.slave  arb,
    output logic [OP_W-1:0]     alu_op_alu,
    output logic [DATA_W-1:0]   alu_in_1,
    output logic [DATA_W-1:0]   alu_in_2,
    input  logic [DATA_W-1:0]   alu_result,
    input  logic                alu_bcond,
    output logic                busy
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t            state;
    logic              owner;
    logic              last_grant;
    logic [OP_W-1:0]   issue_op;
    logic [DATA_W-1:0] issue_in1;
    logic [DATA_W-1:0] issue_in2;
    logic              rsp0_vld_q;
    logic              rsp1_vld_q;
    logic [DATA_W-1:0] rsp0_result_q;
    logic [DATA_W-1:0] rsp1_result_q;
    logic              rsp0_bcond_q;
    logic              rsp1_bcond_q;
    logic              grant0;
    logic              grant1;
    logic              owner_rsp_ready;

    always_comb begin
        grant0 = 1'b0;
`ifdef ALU_ARB_FIXED_PRIO_EN
        grant0 = arb.req0_valid;
`else
        // Port 0 wins a tie only if port 1 had the previous grant.
        grant0 = arb.req0_valid && (!arb.req1_valid || last_grant);
`endif
        grant1 = arb.req1_valid && !grant0;
    end

    assign arb.req0_ready = (state == IDLE) && grant0;
    assign arb.req1_ready = (state == IDLE) && grant1;
    assign owner_rsp_ready = owner ? arb.rsp1_ready : arb.rsp0_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            owner         <= 1'b0;
            last_grant    <= 1'b1;
            issue_op      <= '0;
            issue_in1     <= '0;
            issue_in2     <= '0;
            rsp0_vld_q    <= 1'b0;
            rsp1_vld_q    <= 1'b0;
            rsp0_result_q <= '0;
            rsp1_result_q <= '0;
            rsp0_bcond_q  <= 1'b0;
            rsp1_bcond_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant0 || grant1) begin
                        issue_op  <= grant1 ? arb.req1_op  : arb.req0_op;
                        issue_in1 <= grant1 ? arb.req1_in1 : arb.req0_in1;
                        issue_in2 <= grant1 ? arb.req1_in2 : arb.req0_in2;
                        owner     <= grant1;
`ifndef ALU_ARB_FIXED_PRIO_EN
                        last_grant <= grant1;
`endif
                        state     <= EXEC;
                    end
                end
                EXEC: begin
                    if (owner) begin
                        rsp1_result_q <= alu_result;
                        rsp1_bcond_q  <= alu_bcond;
                        rsp1_vld_q    <= 1'b1;
                    end else begin
                        rsp0_result_q <= alu_result;
                        rsp0_bcond_q  <= alu_bcond;
                        rsp0_vld_q    <= 1'b1;
                    end
                    state <= RESP;
                end
                RESP: begin
                    if (owner_rsp_ready) begin
                        rsp0_vld_q <= 1'b0;
                        rsp1_vld_q <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // ALU is fed only from the issue registers, never combinationally from a request.
    assign alu_op_alu      = issue_op;
    assign alu_in_1        = issue_in1;
    assign alu_in_2        = issue_in2;
    assign arb.rsp0_valid  = rsp0_vld_q;
    assign arb.rsp1_valid  = rsp1_vld_q;
    assign arb.rsp0_result = rsp0_result_q;
    assign arb.rsp1_result = rsp1_result_q;
    assign arb.rsp0_bcond  = rsp0_bcond_q;
    assign arb.rsp1_bcond  = rsp1_bcond_q;
    assign busy            = (state != IDLE);
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: table of single ops plus hand-written contention,
// back-pressure, fairness and mid-op reset sequences; responses checked from a queue.
module tb_alu_share_arbiter;
    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_AND = 4'h2;
    localparam logic [3:0] OP_OR  = 4'h3;
    localparam logic [3:0] OP_XOR = 4'h4;
    localparam logic [3:0] OP_BEQ = 4'hA;
    localparam logic [3:0] OP_BNE = 4'hB;
    localparam logic [3:0] OP_BLT = 4'hC;
    localparam logic [3:0] OP_BGE = 4'hD;

    logic        clk;
    logic        reset_n;
    logic [3:0]  alu_op_alu;
    logic [31:0] alu_in_1;
    logic [31:0] alu_in_2;
    logic [31:0] alu_result;
    logic        alu_bcond;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    alu_share_arbiter_if #(.DATA_W(32), .OP_W(4)) arb ();

    alu_share_arbiter #(.DATA_W(32), .OP_W(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .arb        (arb),
        .alu_op_alu (alu_op_alu),
        .alu_in_1   (alu_in_1),
        .alu_in_2   (alu_in_2),
        .alu_result (alu_result),
        .alu_bcond  (alu_bcond),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-cycle ALU.
    always_comb begin
        alu_result = 32'h0;
        alu_bcond  = 1'b0;
        case (alu_op_alu)
            OP_ADD: alu_result = alu_in_1 + alu_in_2;
            OP_SUB: alu_result = alu_in_1 - alu_in_2;
            OP_AND: alu_result = alu_in_1 & alu_in_2;
            OP_OR:  alu_result = alu_in_1 | alu_in_2;
            OP_XOR: alu_result = alu_in_1 ^ alu_in_2;
            OP_BEQ: alu_bcond  = (alu_in_1 == alu_in_2);
            OP_BNE: alu_bcond  = (alu_in_1 != alu_in_2);
            OP_BLT: alu_bcond  = ($signed(alu_in_1) < $signed(alu_in_2));
            OP_BGE: alu_bcond  = ($signed(alu_in_1) >= $signed(alu_in_2));
            default: ;
        endcase
    end

    typedef struct {
        bit          port;
        logic [31:0] r;
        logic        c;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        bit          port;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic        c;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic push(input bit p, input logic [31:0] r, input logic c);
        exp_t e;
        e.port = p; e.r = r; e.c = c;
        sb.push_back(e);
    endtask

    task automatic check_rsp(input bit p, input logic [31:0] r, input logic c);
        exp_t e;
        if (sb.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL unexpected_rsp: port %0d result %h, no response expected", p, r);
        end else begin
            e = sb.pop_front();
            chk("rsp_port", {31'b0, p}, {31'b0, e.port});
            chk("rsp_result", r, e.r);
            chk("rsp_bcond", {31'b0, c}, {31'b0, e.c});
        end
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            if (arb.rsp0_valid && arb.rsp1_valid) begin
                n_vec++; n_err++;
                $display("FAIL both_rsp_valid: got 1,1 want at most one");
            end
            if (arb.rsp0_valid && arb.rsp0_ready) check_rsp(1'b0, arb.rsp0_result, arb.rsp0_bcond);
            if (arb.rsp1_valid && arb.rsp1_ready) check_rsp(1'b1, arb.rsp1_result, arb.rsp1_bcond);
        end
    end

    task automatic set_req(input bit p, input logic v, input logic [3:0] op,
                           input logic [31:0] a, input logic [31:0] b);
        if (p) begin
            arb.req1_valid = v; arb.req1_op = op; arb.req1_in1 = a; arb.req1_in2 = b;
        end else begin
            arb.req0_valid = v; arb.req0_op = op; arb.req0_in1 = a; arb.req0_in2 = b;
        end
    endtask

    task automatic wait_ready(input bit p, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (p ? arb.req1_ready : arb.req0_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_vec++; n_err++;
            $display("FAIL ready_timeout: port %0d got no ready want ready within 20 cycles", p);
        end
    endtask

    task automatic drain();
        bit done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !busy) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            n_vec++; n_err++;
            $display("FAIL drain_timeout: got %0d pending want 0", sb.size());
        end
    endtask

    task automatic do_req(input bit p, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] r, input logic c);
        bit ok;
        @(posedge clk); #1;
        set_req(p, 1'b1, op, a, b);
        wait_ready(p, ok);
        if (ok) push(p, r, c);
        @(posedge clk); #1;
        set_req(p, 1'b0, op, a, b);
        drain();
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int grants[16];
        int ng;

        tbl[0] = '{1'b1, OP_BEQ, 32'h1234, 32'h1234, 32'h0, 1'b1};
        tbl[1] = '{1'b1, OP_BNE, 32'h1234, 32'h1234, 32'h0, 1'b0};
        tbl[2] = '{1'b0, OP_ADD, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0};
        tbl[3] = '{1'b1, OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0};
        tbl[4] = '{1'b0, OP_OR, 32'h1234_0000, 32'h5678, 32'h1234_5678, 1'b0};
        tbl[5] = '{1'b0, OP_BLT, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b1};
        tbl[6] = '{1'b1, OP_BGE, 32'h5, 32'h5, 32'h0, 1'b1};
        tbl[7] = '{1'b0, OP_SUB, 32'h3, 32'h5, 32'hFFFF_FFFE, 1'b0};

        reset_n = 1'b0;
        set_req(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        set_req(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
        arb.rsp0_ready = 1'b1;
        arb.rsp1_ready = 1'b1;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_req0_ready", {31'b0, arb.req0_ready}, 32'h0);
        chk("rst_req1_ready", {31'b0, arb.req1_ready}, 32'h0);
        chk("rst_rsp0_valid", {31'b0, arb.rsp0_valid}, 32'h0);
        chk("rst_rsp1_valid", {31'b0, arb.rsp1_valid}, 32'h0);
        chk("rst_rsp0_result", arb.rsp0_result, 32'h0);
        chk("rst_rsp1_result", arb.rsp1_result, 32'h0);
        chk("rst_rsp0_bcond", {31'b0, arb.rsp0_bcond}, 32'h0);
        chk("rst_rsp1_bcond", {31'b0, arb.rsp1_bcond}, 32'h0);
        chk("rst_alu_op", {28'b0, alu_op_alu}, 32'h0);
        chk("rst_alu_in_1", alu_in_1, 32'h0);
        chk("rst_alu_in_2", alu_in_2, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        // Contention straight after reset: port 0 first, then port 1
        @(posedge clk); #1;
        set_req(1'b0, 1'b1, OP_SUB, 32'd10, 32'd3);
        set_req(1'b1, 1'b1, OP_XOR, 32'hF0, 32'h0F);
        @(negedge clk);
        chk("cont_req0_ready", {31'b0, arb.req0_ready}, 32'h1);
        chk("cont_req1_ready", {31'b0, arb.req1_ready}, 32'h0);
        push(1'b0, 32'd7, 1'b0);
        @(posedge clk); #1;
        set_req(1'b0, 1'b0, OP_SUB, 32'd10, 32'd3);
        wait_ready(1'b1, ok);
        if (ok) push(1'b1, 32'hFF, 1'b0);
        @(posedge clk); #1;
        set_req(1'b1, 1'b0, OP_XOR, 32'hF0, 32'h0F);
        drain();

        // Single request with cycle-exact latency
        @(posedge clk); #1;
        set_req(1'b0, 1'b1, OP_ADD, 32'd5, 32'd7);
        @(negedge clk);
        chk("t1_ready_c0", {31'b0, arb.req0_ready}, 32'h1);
        push(1'b0, 32'd12, 1'b0);
        @(posedge clk); #1;
        set_req(1'b0, 1'b0, OP_ADD, 32'd5, 32'd7);
        @(negedge clk);
        chk("t1_rsp0_valid_c1", {31'b0, arb.rsp0_valid}, 32'h0);
        chk("t1_busy_c1", {31'b0, busy}, 32'h1);
        chk("t1_alu_op_c1", {28'b0, alu_op_alu}, {28'b0, OP_ADD});
        chk("t1_alu_in_1_c1", alu_in_1, 32'd5);
        chk("t1_alu_in_2_c1", alu_in_2, 32'd7);
        @(negedge clk);
        chk("t1_rsp0_valid_c2", {31'b0, arb.rsp0_valid}, 32'h1);
        chk("t1_rsp1_valid_c2", {31'b0, arb.rsp1_valid}, 32'h0);
        drain();

        for (int i = 0; i < 8; i++)
            do_req(tbl[i].port, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].r, tbl[i].c);

        // Back-pressure on port 0 with port 1 waiting; rsp1_ready on the non-owner is ignored
        arb.rsp0_ready = 1'b0;
        @(posedge clk); #1;
        set_req(1'b0, 1'b1, OP_AND, 32'hFF00, 32'h0FF0);
        wait_ready(1'b0, ok);
        if (ok) push(1'b0, 32'h0F00, 1'b0);
        @(posedge clk); #1;
        set_req(1'b0, 1'b0, OP_AND, 32'hFF00, 32'h0FF0);
        set_req(1'b1, 1'b1, OP_ADD, 32'h10, 32'h20);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_rsp0_valid", {31'b0, arb.rsp0_valid}, 32'h1);
            chk("bp_rsp0_result", arb.rsp0_result, 32'h0F00);
            chk("bp_req1_ready", {31'b0, arb.req1_ready}, 32'h0);
            chk("bp_busy", {31'b0, busy}, 32'h1);
        end
        @(posedge clk); #1;
        arb.rsp0_ready = 1'b1;
        @(negedge clk);
        chk("bp_req1_ready_at_rsp_hs", {31'b0, arb.req1_ready}, 32'h0);
        @(negedge clk);
        chk("bp_idle_busy", {31'b0, busy}, 32'h0);
        chk("bp_idle_req1_ready", {31'b0, arb.req1_ready}, 32'h1);
        if (arb.req1_ready) push(1'b1, 32'h30, 1'b0);
        @(posedge clk); #1;
        set_req(1'b1, 1'b0, OP_ADD, 32'h10, 32'h20);
        drain();

        // Fairness: both requesters held valid for 12 cycles
        ng = 0;
        @(posedge clk); #1;
        set_req(1'b0, 1'b1, OP_ADD, 32'd1, 32'd2);
        set_req(1'b1, 1'b1, OP_SUB, 32'd9, 32'd4);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (arb.req0_ready && arb.req1_ready) begin
                n_vec++; n_err++;
                $display("FAIL rr_double_ready: got both ready want one");
            end else if (arb.req0_ready) begin
                push(1'b0, 32'd3, 1'b0);
                grants[ng] = 0; ng++;
            end else if (arb.req1_ready) begin
                push(1'b1, 32'd5, 1'b0);
                grants[ng] = 1; ng++;
            end
        end
        @(posedge clk); #1;
        set_req(1'b0, 1'b0, OP_ADD, 32'd1, 32'd2);
        set_req(1'b1, 1'b0, OP_SUB, 32'd9, 32'd4);
        drain();
        chk("rr_grant_count", ng, 32'd4);
        if (ng > 0) chk("rr_first_grant", grants[0], 32'd0);
        for (int i = 1; i < ng; i++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            chk("fp_grant", grants[i], 32'd0);
`else
            chk("rr_alternate", grants[i], (grants[i-1] == 0) ? 32'd1 : 32'd0);
`endif
        end

        // Reset during EXEC: outputs clear at once, op is dropped
        @(posedge clk); #1;
        set_req(1'b0, 1'b1, OP_ADD, 32'd100, 32'd200);
        wait_ready(1'b0, ok);
        @(posedge clk); #1;
        set_req(1'b0, 1'b0, OP_ADD, 32'd100, 32'd200);
        chk("mid_busy_exec", {31'b0, busy}, 32'h1);
        #1 reset_n = 1'b0;
        #1;
        chk("mid_rst_busy", {31'b0, busy}, 32'h0);
        chk("mid_rst_rsp0_valid", {31'b0, arb.rsp0_valid}, 32'h0);
        chk("mid_rst_rsp1_valid", {31'b0, arb.rsp1_valid}, 32'h0);
        chk("mid_rst_alu_op", {28'b0, alu_op_alu}, 32'h0);
        chk("mid_rst_alu_in_1", alu_in_1, 32'h0);
        chk("mid_rst_alu_in_2", alu_in_2, 32'h0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("mid_no_stale_rsp0", {31'b0, arb.rsp0_valid}, 32'h0);
        chk("mid_no_stale_busy", {31'b0, busy}, 32'h0);
        do_req(1'b1, OP_XOR, 32'hAAAA, 32'h5555, 32'hFFFF, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares the single-cycle ALU between two requesters: port 0 is the pipeline EX stage and port 1 is the branch/address helper unit.
- Arbitrates between requests, latches the winning operation, and drives the ALU from registers.
- Captures alu_result/alu_bcond and returns them through a per-requester valid/ready response channel.
- Sits between the requesters and the ALU instance. It does not decode opcodes.

Parameters:
- DATA_W, 32, operand/result width.
- OP_W, 4, ALU opcode width. Opcodes are the AluOps.v encodings, passed through unmodified.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_op  in  OP_W  opcode
- req0_in1  in  DATA_W  operand 1
- req0_in2  in  DATA_W  operand 2
- req1_valid, req1_ready, req1_op, req1_in1, req1_in2: same as port 0, for requester 1
- rsp0_valid  out  1  result for requester 0 available
- rsp0_ready  in  1  requester 0 consumes result
- rsp0_result  out  DATA_W  captured alu_result
- rsp0_bcond  out  1  captured alu_bcond
- rsp1_valid, rsp1_ready, rsp1_result, rsp1_bcond: same as port 0, for requester 1
- alu_op_alu  out  OP_W  to ALU
- alu_in_1  out  DATA_W  to ALU
- alu_in_2  out  DATA_W  to ALU
- alu_result  in  DATA_W  from ALU (combinational)
- alu_bcond  in  1  from ALU (combinational)
- busy  out  1  high in any state other than IDLE

Behaviour:
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- Reset values:
  - all readies and rsp valids 0
  - rsp results 0, rsp bconds 0
  - issue registers (op/in1/in2) 0, so the ALU ports read 0
  - owner 0
  - last_grant 1, so requester 0 wins the first contention
- IDLE:
  - Winner = the only valid requester. If both are valid, the requester != last_grant wins.
  - reqN_ready is asserted combinationally for the winner only, and only in IDLE.
  - On handshake: latch op/in1/in2 into the issue registers, set owner=N, set last_grant=N, go to EXEC.
- EXEC (one cycle):
  - ALU ports are driven from the issue registers.
  - At the clock edge, capture alu_result and alu_bcond into the response registers, go to RESP.
- RESP:
  - rsp<owner>_valid=1. The other rsp valid is 0.
  - Hold until rsp<owner>_ready=1, then go to IDLE the next cycle.
  - No new request is accepted while in RESP.
- Latency and throughput:
  - Accept at cycle T, rsp_valid at T+2.
  - Minimum issue interval 3 cycles, when the response is consumed immediately.
- ALU outputs always reflect the issue registers. They stay stable outside EXEC; no combinational path from req to the ALU.
- Both alu_result and alu_bcond are captured for every op:
  - For branch ops (BEQ/BNE/BLT/BGE) the result is whatever the ALU returns (0).
  - For arithmetic ops, bcond is whatever the ALU returns.
  - Consumers select the field they need.
- Protocol rules:
  - A requester holds valid and operands stable until ready. Changing them before ready is a protocol violation; the arbiter samples only at handshake.
  - rsp data is held stable while rsp_valid=1 and ready=0.
- Back-pressure: rsp_ready held low for any number of cycles leaves the FSM in RESP; the other requester waits.
- Simultaneous events:
  - rsp_ready asserted on the non-owner port is ignored.
  - A request arriving in the same cycle as the RESP handshake is accepted no earlier than the following IDLE cycle.
- Reset mid-operation: an in-flight op is discarded, no response is produced, and all outputs return to their reset values immediately (asynchronous).

Optional Feature:
- Macro: ALU_ARB_FIXED_PRIO_EN.
- Defined: requester 0 always wins contention; last_grant is unused (still reset, not updated).
- Undefined (default): round-robin as specified above.
- Single-requester behaviour is identical in both builds.

Test Plan:
1. Single request: req0 op=`ADD, in1=5, in2=7 -> req0_ready in cycle 0; rsp0_valid cycle 2, rsp0_result=12; rsp1_valid stays 0.
2. Contention after reset: req0 and req1 both valid, op=`SUB 10,3 and op=`XOR 0xF0,0x0F -> req0 served first (rsp0_result=7), then req1 (rsp1_result=0xFF). With ALU_ARB_FIXED_PRIO_EN and req0 re-requesting continuously, req1 is never granted.
3. Branch op: req1 `BEQ in1=in2=0x1234 -> rsp1_bcond=1, rsp1_result=0. Then `BNE on the same operands -> rsp1_bcond=0.
4. Back-pressure: rsp0_ready low 5 cycles after `AND 0xFF00,0x0FF0 -> rsp0_valid held, result 0x0F00 stable, req1_ready stays 0, busy=1. The rsp0_ready pulse completes the handshake; IDLE follows.
5. Round-robin fairness: both requesters valid continuously for 12 cycles -> grants alternate 0,1,0,1; each response correct.
6. Reset mid-op: assert reset_n=0 during EXEC -> busy, rsp valids and ALU ports go 0 immediately; after release, no stale response appears; the next request is served normally.
